crypto_block_loader: RTL and testbench
======================================

# crypto_block_loader

Front-end stage of the crypto coprocessor, directly upstream of the AES core. It decodes the 32-bit instruction bus, performs configuration-register writes, and assembles four consecutive 32-bit data words into one 128-bit block. It hands that block to the core over a valid/ready handshake and holds off new loads while a block is still pending.

## Interface
- `WORD_W`, 32: width of `instruct` and of config data.
- `WORDS`, 4: words per block; block width is `WORD_W*WORDS`.
- `GAP_CYCLES`, 1: number of ignored cycles between a LOAD command and the first data word.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `instruct` in `WORD_W`: instruction/data bus, sampled every rising edge.
- `block_data` out `WORD_W*WORDS`: assembled block. The first captured word is bits [31:0]; the last is the MSW.
- `block_valid` out 1: block available for the core.
- `block_ready` in 1: core accepts the block.
- `cfg_wr_en` out 1: one-cycle config write strobe.
- `cfg_addr` out 4: config register index.
- `cfg_wr_data` out `WORD_W`: config write value.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: sticky flag, set when a LOAD is dropped.

## Operation
- **Command word:** `instruct[31:28]==4'h4` and `instruct[27:8]==0`. Sub-code is `instruct[7:0]`.
  - `8'h00`: LOAD.
  - `8'h01`–`8'h0F`: CONFIG, with index `instruct[3:0]`.
  - Other sub-codes are ignored.
- **Other words:** `32'h0` is a NOP. Any non-command word in IDLE is ignored.
- **FSM states:** IDLE, CFG_VAL, GAP, COLLECT, PEND.
  - IDLE + CONFIG → CFG_VAL, latching `cfg_addr`.
  - CFG_VAL: the next word is taken unconditionally as the value. `cfg_wr_data` ← word, `cfg_wr_en` pulses for one cycle, then → IDLE.
  - IDLE + LOAD → GAP. GAP lasts `GAP_CYCLES` cycles and `instruct` is ignored throughout.
  - GAP → COLLECT. COLLECT captures `WORDS` consecutive words unconditionally into slot 0..3 using a 2-bit word counter. Command-like values are treated as data.
  - After the last word: `block_valid`←1, → PEND.
  - PEND + `block_ready`: `block_valid`←0, → IDLE.
- **CONFIG in PEND:** handled via CFG_VAL, then return to PEND. `block_valid` stays high throughout.
- **LOAD in PEND:**
  - With `block_ready` high in the same cycle: the handshake completes and the LOAD is accepted (→ GAP).
  - Otherwise: the LOAD is dropped and `overrun`←1.
- **Clearing `overrun`:** only by reset.
- **`block_data` stability:** holds its value from the `block_valid` rise until the next COLLECT starts overwriting slot 0.
- **Reset:** at any time, all outputs go to 0 and the FSM goes to IDLE. A partial block is discarded and does not raise `overrun`.

## Timing
- Edge numbering: LOAD sampled at edge n, gap word at n+1, data words at n+2..n+5.
- `block_valid` is high from the cycle after edge n+5. `busy` is high from the cycle after edge n.
- CONFIG sampled at edge n, value at n+1. `cfg_wr_en` is high for exactly the cycle after edge n+1.
- Handshake:
  - Transfer occurs on an edge where `block_valid` and `block_ready` are both high.
  - `block_valid` drops in the following cycle.
  - `block_ready` while not valid has no effect.
- Back-to-back operation: a LOAD sampled on the handshake edge gives a minimum of 6 cycles between successive `block_valid` rises.
- All outputs are registered; there is no combinational path from `instruct` or `block_ready`.

## Structure
- Shared package `crypto_pkg` holds:
  - `CMD_TAG` = `4'h4`.
  - `SUB_LOAD` = `8'h00`.
  - The CONFIG sub-code range.
  - The `loader_state_t` enum.
  - `BLOCK_W` = 128.
- One sub-module, `crypto_cmd_decode`: a combinational classifier producing `is_load`, `is_cfg` and `cfg_idx` from `instruct`. The FSM, word counter and block register live in the top.

## Test plan
- **CONFIG write:** apply `40000003` then `00000094` → `cfg_wr_en` is a single pulse with `cfg_addr`=3 and `cfg_wr_data`=`00000094`. `busy` returns to 0.
- **LOAD and collect:** apply `40000000` ×2, then `7393172a`, `e93d7e11`, `2e409f96`, `6bc1bee2`, with `block_ready` low → `block_valid`=1 and `block_data`=`6bc1bee2_2e409f96_e93d7e11_7393172a`, held stable over 10 cycles.
- **Handshake:** assert `block_ready` for one cycle → `block_valid`=0 the next cycle. Then a LOAD of `45af8e51`, `9eb76fac`, `1e03ac9c`, `ae2d8a57` → `block_data`=`ae2d8a57_1e03ac9c_9eb76fac_45af8e51`.
- **Overrun versus accepted LOAD:**
  - In PEND, a LOAD with `block_ready` low → `overrun`=1, the block is unchanged and the state stays PEND.
  - Repeat with `block_ready` high on the LOAD edge → the LOAD is accepted and `overrun` does not change.
- **Command-like data word:** use `40000000` as data word 2 → it is captured verbatim into bits [63:32]. No state change.
- **Reset mid-operation:** pull `reset_n` low after 2 data words → all outputs go to 0 immediately. After release, a fresh full LOAD yields the correct block with `overrun`=0.

Source files
------------

// File: rtl/crypto_pkg.sv
// Shared constants and types for the crypto coprocessor front end.
package crypto_pkg;
  localparam logic [3:0] CMD_TAG    = 4'h4;
  localparam logic [7:0] SUB_LOAD   = 8'h00;
  localparam logic [7:0] SUB_CFG_LO = 8'h01;
  localparam logic [7:0] SUB_CFG_HI = 8'h0F;
  localparam int         BLOCK_W    = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_VAL,
    ST_GAP,
    ST_COLLECT,
    ST_PEND
  } loader_state_t;
endpackage

// File: rtl/crypto_cmd_decode.sv
// Combinational classifier for the instruction bus: LOAD / CONFIG detection.
module crypto_cmd_decode
  import crypto_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] instruct,
  output logic              is_load,
  output logic              is_cfg,
  output logic [3:0]        cfg_idx
);
  logic       is_cmd;
  logic [7:0] sub;

  assign is_cmd  = (instruct[31:28] == CMD_TAG) && (instruct[27:8] == 20'h0);
  assign sub     = instruct[7:0];
  assign is_load = is_cmd && (sub == SUB_LOAD);
  assign is_cfg  = is_cmd && (sub >= SUB_CFG_LO) && (sub <= SUB_CFG_HI);
  assign cfg_idx = instruct[3:0];
endmodule

// File: rtl/crypto_block_loader.sv
// Instruction decode, config writes and 128-bit block assembly ahead of the AES core.
module crypto_block_loader
  import crypto_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int WORDS      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [WORD_W-1:0]         instruct,
  output logic [WORD_W*WORDS-1:0]   block_data,
  output logic                      block_valid,
  input  logic                      block_ready,
  output logic                      cfg_wr_en,
  output logic [3:0]                cfg_addr,
  output logic [WORD_W-1:0]         cfg_wr_data,
  output logic                      busy,
  output logic                      overrun
);
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  loader_state_t                  state;
  logic [CW-1:0]                  wcnt;
  logic [GW-1:0]                  gap_cnt;
  logic [WORDS-1:0][WORD_W-1:0]   blk;
  logic                           is_load, is_cfg;
  logic [3:0]                     cfg_idx;

  crypto_cmd_decode #(.WORD_W(WORD_W)) u_dec (
    .instruct (instruct),
    .is_load  (is_load),
    .is_cfg   (is_cfg),
    .cfg_idx  (cfg_idx)
  );

  assign block_data = blk;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      gap_cnt     <= '0;
      blk         <= '0;
      block_valid <= 1'b0;
      cfg_wr_en   <= 1'b0;
      cfg_addr    <= '0;
      cfg_wr_data <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      cfg_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (is_load) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
            busy    <= 1'b1;
          end else if (is_cfg) begin
            cfg_addr <= cfg_idx;
            state    <= ST_CFG_VAL;
            busy     <= 1'b1;
          end
        end
        ST_CFG_VAL: begin
          cfg_wr_data <= instruct;
          cfg_wr_en   <= 1'b1;
          // A pending block survives the config detour unless it is taken now.
          if (block_valid && !block_ready) begin
            state <= ST_PEND;
          end else begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            block_valid <= 1'b0;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= ST_COLLECT;
            wcnt  <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        ST_COLLECT: begin
          blk[wcnt] <= instruct;
          wcnt      <= wcnt + CW'(1);
          if (wcnt == CW'(WORDS - 1)) begin
            block_valid <= 1'b1;
            state       <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (block_ready) block_valid <= 1'b0;
          if (is_load) begin
            if (block_ready) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else begin
              overrun <= 1'b1;
            end
          end else if (is_cfg) begin
            cfg_addr <= cfg_idx;
            state    <= ST_CFG_VAL;
          end else if (block_ready) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_crypto_block_loader.sv
// Scoreboard bench for crypto_block_loader: expected blocks/config writes queued at drive time.
module tb_crypto_block_loader;
  logic         clock = 1'b0;
  logic         reset_n;
  logic [31:0]  instruct;
  logic [127:0] block_data;
  logic         block_valid, block_ready, cfg_wr_en, busy, overrun;
  logic [3:0]   cfg_addr;
  logic [31:0]  cfg_wr_data;

  int tests = 0;
  int fails = 0;

  logic [127:0] bq[$];
  logic [35:0]  cq[$];
  logic         pv = 1'b0;
  logic         pc = 1'b0;

  localparam logic [31:0] LD = 32'h4000_0000;
  localparam logic [127:0] B1 = {32'h6bc1bee2, 32'h2e409f96, 32'he93d7e11, 32'h7393172a};
  localparam logic [127:0] B2 = {32'hae2d8a57, 32'h1e03ac9c, 32'h9eb76fac, 32'h45af8e51};
  localparam logic [127:0] B3 = {32'h30c81c46, 32'ha35ce411, 32'h40000000, 32'hf69f2445};
  localparam logic [127:0] B4 = {32'h11223344, 32'h55667788, 32'h99aabbcc, 32'hddeeff00};

  crypto_block_loader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instruct    (instruct),
    .block_data  (block_data),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_addr    (cfg_addr),
    .cfg_wr_data (cfg_wr_data),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] w, input logic rdy);
    instruct    = w;
    block_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic load_block(input logic [127:0] b, input logic rdy_first);
    drive(LD, rdy_first);
    drive(LD, 1'b0);
    for (int i = 0; i < 4; i++) drive(b[i*32 +: 32], 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},  block_data, '0);
    chk({tag, "_valid"}, {127'h0, block_valid}, '0);
    chk({tag, "_cfgen"}, {127'h0, cfg_wr_en}, '0);
    chk({tag, "_cfga"},  {124'h0, cfg_addr}, '0);
    chk({tag, "_cfgd"},  {96'h0, cfg_wr_data}, '0);
    chk({tag, "_busy"},  {127'h0, busy}, '0);
    chk({tag, "_ovr"},   {127'h0, overrun}, '0);
  endtask

  // Output monitor: pops the scoreboard on each block_valid rise and each config strobe.
  always @(negedge clock) begin
    if (!reset_n) begin
      pv <= 1'b0;
      pc <= 1'b0;
    end else begin
      if (block_valid && !pv) begin
        if (bq.size() == 0) chk("blk_unexpected", 128'h1, 128'h0);
        else chk("blk_data", block_data, bq.pop_front());
      end
      if (cfg_wr_en) begin
        if (pc) chk("cfg_pulse_width", 128'h1, 128'h0);
        if (cq.size() == 0) chk("cfg_unexpected", 128'h1, 128'h0);
        else chk("cfg_write", {92'h0, cfg_addr, cfg_wr_data}, {92'h0, cq.pop_front()});
      end
      pv <= block_valid;
      pc <= cfg_wr_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    instruct = '0;
    block_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_zero("rst");
    @(negedge clock);
    reset_n = 1'b1;
    drive(32'h0, 1'b0);

    // CONFIG write
    cq.push_back({4'h3, 32'h0000_0094});
    drive(32'h4000_0003, 1'b0);
    chk("cfg_busy", {127'h0, busy}, 128'h1);
    drive(32'h0000_0094, 1'b0);
    chk("cfg_en_hi", {127'h0, cfg_wr_en}, 128'h1);
    drive(32'h0, 1'b0);
    chk("cfg_en_lo", {127'h0, cfg_wr_en}, 128'h0);
    chk("cfg_busy_done", {127'h0, busy}, 128'h0);

    // LOAD and hold
    bq.push_back(B1);
    drive(LD, 1'b0);
    chk("load_busy", {127'h0, busy}, 128'h1);
    drive(LD, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("collect_valid_lo", {127'h0, block_valid}, 128'h0);
      drive(B1[i*32 +: 32], 1'b0);
    end
    chk("b1_valid", {127'h0, block_valid}, 128'h1);
    for (int i = 0; i < 10; i++) begin
      drive(32'h0, 1'b0);
      chk("b1_hold", block_data, B1);
    end
    chk("b1_valid_held", {127'h0, block_valid}, 128'h1);

    // Handshake, then second block
    drive(32'h0, 1'b1);
    chk("hs_valid_lo", {127'h0, block_valid}, 128'h0);
    chk("hs_busy_lo", {127'h0, busy}, 128'h0);
    drive(32'h0, 1'b0);
    bq.push_back(B2);
    load_block(B2, 1'b0);
    chk("b2_valid", {127'h0, block_valid}, 128'h1);
    chk("b2_data", block_data, B2);

    // LOAD accepted on the handshake edge; command-like word as data slot 1
    bq.push_back(B3);
    load_block(B3, 1'b1);
    chk("acc_ovr", {127'h0, overrun}, 128'h0);
    chk("b3_data", block_data, B3);
    chk("b3_slot1", {96'h0, block_data[63:32]}, {96'h0, 32'h4000_0000});

    // CONFIG while a block is pending
    cq.push_back({4'h5, 32'hdead_beef});
    drive(32'h4000_0005, 1'b0);
    chk("pcfg_valid1", {127'h0, block_valid}, 128'h1);
    drive(32'hdead_beef, 1'b0);
    chk("pcfg_valid2", {127'h0, block_valid}, 128'h1);
    drive(32'h0, 1'b0);
    chk("pcfg_busy", {127'h0, busy}, 128'h1);
    chk("pcfg_valid3", {127'h0, block_valid}, 128'h1);

    // Dropped LOAD
    drive(LD, 1'b0);
    chk("ovr_set", {127'h0, overrun}, 128'h1);
    chk("ovr_valid", {127'h0, block_valid}, 128'h1);
    drive(32'h1234_5678, 1'b0);
    drive(32'h9abc_def0, 1'b0);
    chk("ovr_block_kept", block_data, B3);
    chk("ovr_still_pend", {127'h0, block_valid}, 128'h1);
    drive(32'h0, 1'b1);
    chk("ovr_hs_valid", {127'h0, block_valid}, 128'h0);
    chk("ovr_sticky", {127'h0, overrun}, 128'h1);

    // Reset in the middle of a collect
    drive(LD, 1'b0);
    drive(LD, 1'b0);
    drive(32'haaaa_0001, 1'b0);
    drive(32'haaaa_0002, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clock);
    reset_n = 1'b1;
    drive(32'h0, 1'b0);
    bq.push_back(B4);
    load_block(B4, 1'b0);
    chk("b4_valid", {127'h0, block_valid}, 128'h1);
    chk("b4_data", block_data, B4);
    chk("b4_ovr", {127'h0, overrun}, 128'h0);
    drive(32'h0, 1'b1);
    drive(32'h0, 1'b0);
    drive(32'h0, 1'b0);

    chk("sb_empty", 128'(bq.size() + cq.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
